// File: rtl/wavegen_pkg.sv
// wavegen_pkg: shared types, constants and the quarter-sine table
// generator for the dual-channel DDS sample engine.
package wavegen_pkg;

  typedef enum logic [2:0] {
    WM_DC     = 3'd0,
    WM_SINE   = 3'd1,
    WM_SAW    = 3'd2,
    WM_TRI    = 3'd3,
    WM_SQUARE = 3'd4
  } wave_mode_e;

  localparam int DAC_W    = 12;
  localparam int MIDSCALE = 2048;
  localparam int WAVE_MAX = 2047;
  localparam int LUT_N    = 1024;

  // round(2047*sin(pi/2*k/1024)), evaluated at elaboration time
  function automatic logic [10:0] qsin(input int k);
    real x;
    real t;
    real s;
    x = 3.14159265358979323846 * real'(k) / 2048.0;
    t = x;
    s = x;
    for (int n = 1; n < 12; n++) begin
      t = -t * x * x / real'((2 * n) * (2 * n + 1));
      s = s + t;
    end
    return 11'($rtoi(2047.0 * s + 0.5));
  endfunction

endpackage

// File: rtl/wavegen_dds_core_if.sv
// wavegen_dds_core_if: sample request, per-channel configuration
// and DAC sample outputs of the DDS engine.
interface wavegen_dds_core_if #(
  parameter int PHASE_W = 32
);
  logic               sample_tick;
  logic               phase_sync;
  logic [2:0]         mode_a;
  logic [2:0]         mode_b;
  logic [PHASE_W-1:0] ftw_a;
  logic [PHASE_W-1:0] ftw_b;
  logic [15:0]        amp_a;
  logic [15:0]        amp_b;
  logic [15:0]        offset_a;
  logic [15:0]        offset_b;
  logic [PHASE_W-1:0] phase_off_b;
  logic [11:0]        dac_a;
  logic [11:0]        dac_b;
  logic               sample_valid;

  modport master (
    output sample_tick, phase_sync,
    output mode_a, mode_b, ftw_a, ftw_b,
    output amp_a, amp_b, offset_a, offset_b,
    output phase_off_b,
    input  dac_a, dac_b, sample_valid
  );

  modport slave (
    input  sample_tick, phase_sync,
    input  mode_a, mode_b, ftw_a, ftw_b,
    input  amp_a, amp_b, offset_a, offset_b,
    input  phase_off_b,
    output dac_a, dac_b, sample_valid
  );
endinterface

// File: rtl/wavegen_channel.sv
// wavegen_channel: phase accumulator plus the four-stage
// capture / waveform / scale / offset-saturate pipeline.
module wavegen_channel
  import wavegen_pkg::*;
#(
  parameter int PHASE_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               sync,
  input  logic               ld,
  input  logic [PHASE_W-1:0] sync_val,
  input  logic [PHASE_W-1:0] ftw,
  input  logic [2:0]         mode,
  input  logic [15:0]        amp,
  input  logic [15:0]        offset,
  output logic [DAC_W-1:0]   dac
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] cur;
  logic [11:0]        p;
  logic [2:0]         mode0;
  logic [15:0]        amp0, amp1;
  logic [15:0]        off0, off1, off2;
  logic [10:0]        idx;
  logic [10:0]        mag;
  logic [12:0]        t2;
  logic [10:0]        lut [LUT_N];
  logic signed [11:0] w, w1;
  logic signed [28:0] prod;
  logic signed [13:0] s, s2;
  logic signed [17:0] r;
  logic [DAC_W-1:0]   dac_n;

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam logic [10:0] V = qsin(k);
    assign lut[k] = V;
  end

  assign cur = sync ? sync_val : phase;

  // accumulator: sync realigns, a tick advances from the sample phase
  always_ff @(posedge clk) begin
    if (reset)     phase <= '0;
    else if (tick) phase <= cur + ftw;
    else if (sync) phase <= sync_val;
  end

  // S0: capture sample phase and config together
  always_ff @(posedge clk) begin
    if (tick) begin
      p     <= cur[PHASE_W-1 -: 12];
      mode0 <= mode;
      amp0  <= amp;
      off0  <= offset;
    end
  end

  // S1 combinational: waveform shape from the 12-bit phase
  always_comb begin
    idx = p[10] ? 11'd1024 - {1'b0, p[9:0]} : {1'b0, p[9:0]};
    mag = idx[10] ? 11'(WAVE_MAX) : lut[idx[9:0]];
    t2  = {p, 1'b0};
    w   = '0;
    unique case (1'b1)
      mode0 == WM_SINE:
        w = p[11] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
      mode0 == WM_SAW:
        w = $signed({~p[11], p[10:0]});
      mode0 == WM_TRI:
        w = p[11] ? 12'(13'd6143 - t2) : 12'(t2 - 13'd2048);
      mode0 == WM_SQUARE:
        w = p[11] ? -12'sd2047 : 12'sd2047;
      default:
        w = '0;
    endcase
  end

  // S1 register: waveform sample, config follows
  always_ff @(posedge clk) begin
    w1   <= w;
    amp1 <= amp0;
    off1 <= off0;
  end

  // S2 combinational: Q1.15 gain with floor rounding
  always_comb begin
    prod = 29'(w1) * 29'($signed({1'b0, amp1}));
    s    = 14'(prod >>> 15);
  end

  // S2 register: scaled sample, offset follows
  always_ff @(posedge clk) begin
    s2   <= s;
    off2 <= off1;
  end

  // S3 combinational: add offset and clamp to DAC range
  always_comb begin
    r = 18'(s2) + 18'($signed(off2));
    if (r[17])              dac_n = '0;
    else if (r > 18'sd4095) dac_n = '1;
    else                    dac_n = r[11:0];
  end

  // S3 register: DAC code updates only on a valid sample
  always_ff @(posedge clk) begin
    if (reset)   dac <= DAC_W'(MIDSCALE);
    else if (ld) dac <= dac_n;
  end

endmodule

// File: rtl/wavegen_dds_core.sv
// wavegen_dds_core: two DDS channels, sync fan-out, valid alignment.
// Define WAVEGEN_INT_TICK_EN to use an internal TICK_DIV sample clock.
module wavegen_dds_core
  import wavegen_pkg::*;
#(
  parameter int PHASE_W = 32
`ifdef WAVEGEN_INT_TICK_EN
  ,
  parameter int TICK_DIV = 2000
`endif
) (
  input logic              clk,
  input logic              reset,
  wavegen_dds_core_if.slave bus
);

  logic       tick;
  logic [2:0] vld;
  logic       valid_q;

`ifdef WAVEGEN_INT_TICK_EN
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);
  logic [CW-1:0] cnt;

  assign tick = (cnt == CMAX);

  // free-running sample-rate divider
  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end
`else
  assign tick = bus.sample_tick;
`endif

  // valid shift register aligned with the channel pipelines
  always_ff @(posedge clk) begin
    if (reset) begin
      vld     <= '0;
      valid_q <= 1'b0;
    end else begin
      vld     <= {vld[1:0], tick};
      valid_q <= vld[2];
    end
  end

  assign bus.sample_valid = valid_q;

  wavegen_channel #(.PHASE_W(PHASE_W)) u_ch_a (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .sync     (bus.phase_sync),
    .ld       (vld[2]),
    .sync_val ('0),
    .ftw      (bus.ftw_a),
    .mode     (bus.mode_a),
    .amp      (bus.amp_a),
    .offset   (bus.offset_a),
    .dac      (bus.dac_a)
  );

  wavegen_channel #(.PHASE_W(PHASE_W)) u_ch_b (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .sync     (bus.phase_sync),
    .ld       (vld[2]),
    .sync_val (bus.phase_off_b),
    .ftw      (bus.ftw_b),
    .mode     (bus.mode_b),
    .amp      (bus.amp_b),
    .offset   (bus.offset_b),
    .dac      (bus.dac_b)
  );

endmodule

// File: tb/tb_wavegen_dds_core.sv
// tb_wavegen_dds_core: directed vectors with hand-computed
// expectations for the dual-channel DDS engine.
module tb_wavegen_dds_core;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   k;
  int   n;

  always #5 clk = ~clk;

  wavegen_dds_core_if bus ();

  wavegen_dds_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // one isolated tick; checks latency and both DAC codes
  task automatic tick_check(input string tag, input int ea,
                            input int eb);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    bus.phase_sync  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, ".early_v"}, 32'(bus.sample_valid), 0);
    @(negedge clk);
    chk({tag, ".v"}, 32'(bus.sample_valid), 1);
    chk({tag, ".a"}, 32'(bus.dac_a), ea);
    chk({tag, ".b"}, 32'(bus.dac_b), eb);
  endtask

  initial begin
    reset           = 1'b1;
    bus.sample_tick = 1'b0;
    bus.phase_sync  = 1'b0;
    bus.mode_a      = 3'd0;
    bus.mode_b      = 3'd0;
    bus.ftw_a       = '0;
    bus.ftw_b       = '0;
    bus.amp_a       = 16'h8000;
    bus.amp_b       = 16'h8000;
    bus.offset_a    = 16'd0;
    bus.offset_b    = 16'd0;
    bus.phase_off_b = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.a", 32'(bus.dac_a), 2048);
    chk("rst.b", 32'(bus.dac_b), 2048);
    chk("rst.v", 32'(bus.sample_valid), 0);

`ifdef WAVEGEN_INT_TICK_EN
    bus.offset_a = 16'd123;
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.sample_valid && n < 5000);
    chk("itick.first", 32'(n), 2003);
    chk("itick.a", 32'(bus.dac_a), 123);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.sample_valid && n < 5000);
    chk("itick.gap", 32'(n), 2000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.sample_valid && n < 5000);
    chk("itick.gap2", 32'(n), 2000);
`else
    // DC with offsets
    bus.offset_a = 16'd1000;
    bus.offset_b = 16'd500;
    reset = 1'b0;
    tick_check("dc", 1000, 500);
    @(negedge clk);
    chk("dc.hold_v", 32'(bus.sample_valid), 0);
    chk("dc.hold_a", 32'(bus.dac_a), 1000);

    // SAW sweep with wrap; B at half gain, zero offset
    do_reset();
    bus.mode_a   = 3'd2;
    bus.mode_b   = 3'd2;
    bus.ftw_a    = 32'h0010_0000;
    bus.ftw_b    = 32'h0010_0000;
    bus.amp_a    = 16'h8000;
    bus.amp_b    = 16'h4000;
    bus.offset_a = 16'd2048;
    bus.offset_b = 16'd0;
    bus.sample_tick = 1'b1;
    for (int i = 0; i < 4100; i++) begin
      @(negedge clk);
      if (i == 4096) bus.sample_tick = 1'b0;
      if (i >= 3) begin
        k = (i - 3) % 4096;
        chk("saw.v", 32'(bus.sample_valid), 1);
        chk("saw.a", 32'(bus.dac_a), k);
        chk("saw.b", 32'(bus.dac_b), k < 2048 ? 0 : (k - 2048) / 2);
      end
    end
    @(negedge clk);
    chk("saw.end_v", 32'(bus.sample_valid), 0);

    // SINE on A, TRI on B, quarter-turn steps
    do_reset();
    bus.mode_a   = 3'd1;
    bus.mode_b   = 3'd3;
    bus.ftw_a    = 32'h4000_0000;
    bus.ftw_b    = 32'h4000_0000;
    bus.amp_a    = 16'h8000;
    bus.amp_b    = 16'h8000;
    bus.offset_a = 16'd2048;
    bus.offset_b = 16'd2048;
    tick_check("sin_tri0", 2048, 0);
    tick_check("sin_tri1", 4095, 2048);
    tick_check("sin_tri2", 2048, 4095);
    tick_check("sin_tri3", 1, 2047);
    tick_check("sin_tri4", 2048, 0);

    // SQUARE over-gain on A, half-gain SAW + small offset on B
    do_reset();
    bus.mode_a   = 3'd4;
    bus.mode_b   = 3'd2;
    bus.amp_a    = 16'hFFFF;
    bus.amp_b    = 16'h4000;
    bus.offset_b = 16'd100;
    tick_check("sq0", 4095, 0);
    tick_check("sq1", 4095, 0);
    tick_check("sq2", 0, 100);
    tick_check("sq3", 0, 612);

    // phase_sync, coincident and standalone
    do_reset();
    bus.mode_a      = 3'd2;
    bus.mode_b      = 3'd2;
    bus.ftw_a       = 32'h0010_0000;
    bus.ftw_b       = 32'h0010_0000;
    bus.amp_a       = 16'h8000;
    bus.amp_b       = 16'h8000;
    bus.offset_a    = 16'd2048;
    bus.offset_b    = 16'd2048;
    bus.phase_off_b = 32'h8000_0000;
    tick_check("sync.pre0", 0, 0);
    tick_check("sync.pre1", 1, 1);
    bus.phase_sync = 1'b1;
    tick_check("sync.co0", 0, 2048);
    tick_check("sync.co1", 1, 2049);
    bus.phase_sync = 1'b1;
    @(negedge clk);
    bus.phase_sync = 1'b0;
    tick_check("sync.solo", 0, 2048);

    // back-to-back ticks, amp changed each cycle
    do_reset();
    bus.mode_a   = 3'd4;
    bus.mode_b   = 3'd4;
    bus.ftw_a    = 32'h0;
    bus.ftw_b    = 32'h8000_0000;
    bus.offset_a = 16'd0;
    bus.offset_b = 16'd2048;
    bus.amp_a    = 16'h8000;
    bus.amp_b    = 16'h8000;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.amp_a = 16'h4000;
    bus.amp_b = 16'h4000;
    @(negedge clk);
    bus.amp_a = 16'h2000;
    bus.amp_b = 16'h2000;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    bus.amp_a  = 16'hFFFF;
    bus.amp_b  = 16'hFFFF;
    bus.mode_a = 3'd0;
    chk("b2b.pre_v", 32'(bus.sample_valid), 0);
    @(negedge clk);
    chk("b2b0.v", 32'(bus.sample_valid), 1);
    chk("b2b0.a", 32'(bus.dac_a), 2047);
    chk("b2b0.b", 32'(bus.dac_b), 4095);
    @(negedge clk);
    chk("b2b1.v", 32'(bus.sample_valid), 1);
    chk("b2b1.a", 32'(bus.dac_a), 1023);
    chk("b2b1.b", 32'(bus.dac_b), 1024);
    @(negedge clk);
    chk("b2b2.v", 32'(bus.sample_valid), 1);
    chk("b2b2.a", 32'(bus.dac_a), 511);
    chk("b2b2.b", 32'(bus.dac_b), 2559);
    @(negedge clk);
    chk("b2b.end_v", 32'(bus.sample_valid), 0);
    chk("b2b.hold_a", 32'(bus.dac_a), 511);

    // reset while a sample is in flight
    bus.offset_a = 16'd77;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid.a", 32'(bus.dac_a), 2048);
    chk("mid.b", 32'(bus.dac_b), 2048);
    chk("mid.v", 32'(bus.sample_valid), 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid.after_v", 32'(bus.sample_valid), 0);
      chk("mid.after_a", 32'(bus.dac_a), 2048);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
